// File: rtl/seq_mul_pkg.sv
// Shared types and defaults for the sequential shift-add multiplier.
package seq_mul_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } seq_mul_state_t;

   localparam int unsigned SEQ_MUL_DEF_WIDTH = 16;

endpackage : seq_mul_pkg

// File: rtl/mul_acc_step.sv
// One right-shift multiply step: add (or, on the final signed step, subtract)
// the partial product into the high half, then shift the accumulator right by one.
module mul_acc_step
   import seq_mul_pkg::*;
#(
   parameter int unsigned WIDTH = SEQ_MUL_DEF_WIDTH
) (
   input  logic [2*WIDTH:0] acc,
   input  logic [WIDTH-1:0] pp,
   input  logic             is_signed,
   input  logic             last,
   output logic [2*WIDTH:0] next_acc_c
);

   localparam int unsigned SUM_W = WIDTH + 2;

   logic [SUM_W-1:0] hi_ext_c;
   logic [SUM_W-1:0] pp_ext_c;
   logic [SUM_W-1:0] sum_c;

   // Sum is one bit wider than hi so the shifted-out sign stays exact.
   always_comb begin
      hi_ext_c   = '0;
      pp_ext_c   = '0;
      sum_c      = '0;
      next_acc_c = '0;
      if (is_signed) begin
         hi_ext_c = {acc[2*WIDTH], acc[2*WIDTH:WIDTH]};
         pp_ext_c = {pp[WIDTH-1], pp[WIDTH-1], pp};
      end else begin
         hi_ext_c = {2'b00, acc[2*WIDTH-1:WIDTH]};
         pp_ext_c = {2'b00, pp};
      end
      sum_c      = (is_signed && last) ? (hi_ext_c - pp_ext_c) : (hi_ext_c + pp_ext_c);
      next_acc_c = {sum_c, acc[WIDTH-1:1]};
   end

endmodule : mul_acc_step

// File: rtl/seq_mul_engine.sv
// Sequential WIDTH x WIDTH -> 2*WIDTH shift-add multiplier with valid/ready handshakes.
// Define SEQ_MUL_EARLY_TERM_EN to finish as soon as the remaining multiplier bits are zero.
module seq_mul_engine
   import seq_mul_pkg::*;
#(
   parameter int unsigned WIDTH = SEQ_MUL_DEF_WIDTH
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               in_signed,
   input  logic [WIDTH-1:0]   in_mcand,
   input  logic [WIDTH-1:0]   in_mplier,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] out_product,
   output logic               busy
);

   localparam int unsigned CNT_W  = $clog2(WIDTH);
   localparam int unsigned CNT1_W = CNT_W + 1;
   localparam int unsigned ACC_W  = 2*WIDTH + 1;

   seq_mul_state_t   state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] mcand_q;
   logic [WIDTH-1:0] mplier_q;
   logic             signed_q;
   logic [ACC_W-1:0] acc;

   logic [WIDTH-1:0] pp_c;
   logic             last_c;
   logic             fin_c;
   logic [ACC_W-1:0] step_acc_c;
   logic [ACC_W-1:0] next_acc_c;

   assign pp_c   = mplier_q[cnt] ? mcand_q : '0;
   assign last_c = (cnt == CNT_W'(WIDTH - 1));

   mul_acc_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .acc        (acc),
      .pp         (pp_c),
      .is_signed  (signed_q),
      .last       (last_c),
      .next_acc_c (step_acc_c)
   );

`ifdef SEQ_MUL_EARLY_TERM_EN
   logic [WIDTH-1:0]  upper_c;
   logic [CNT1_W-1:0] rem_c;

   // Skipped steps would add zero, so an arithmetic shift by the remaining count is equivalent.
   always_comb begin
      upper_c    = mplier_q >> (CNT1_W'(cnt) + CNT1_W'(1));
      rem_c      = CNT1_W'(WIDTH - 1) - CNT1_W'(cnt);
      fin_c      = last_c | (upper_c == '0);
      next_acc_c = ACC_W'($signed(step_acc_c) >>> rem_c);
   end
`else
   assign fin_c      = last_c;
   assign next_acc_c = step_acc_c;
`endif

   // Control FSM, operand capture and registered handshake outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         in_ready    <= 1'b1;
         out_valid   <= 1'b0;
         busy        <= 1'b0;
         out_product <= '0;
         cnt         <= '0;
         acc         <= '0;
         mcand_q     <= '0;
         mplier_q    <= '0;
         signed_q    <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  mcand_q  <= in_mcand;
                  mplier_q <= in_mplier;
                  signed_q <= in_signed;
                  acc      <= '0;
                  cnt      <= '0;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  state    <= CALC;
               end
            end
            CALC: begin
               acc <= next_acc_c;
               cnt <= cnt + CNT_W'(1);
               if (fin_c) begin
                  out_product <= next_acc_c[2*WIDTH-1:0];
                  out_valid   <= 1'b1;
                  state       <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule : seq_mul_engine

// File: tb/tb_seq_mul_engine.sv
// Scoreboard bench for seq_mul_engine at WIDTH=16: directed corner cases, backpressure,
// mid-operation reset and randomized back-to-back traffic against an arithmetic model.
module tb_seq_mul_engine;

   localparam int unsigned W  = 16;
   localparam int unsigned PW = 2*W;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic          in_signed;
   logic [W-1:0]  in_mcand;
   logic [W-1:0]  in_mplier;
   logic          out_valid;
   logic          out_ready;
   logic [PW-1:0] out_product;
   logic          busy;

   seq_mul_engine #(
      .WIDTH (W)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_signed   (in_signed),
      .in_mcand    (in_mcand),
      .in_mplier   (in_mplier),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_product (out_product),
      .busy        (busy)
   );

   typedef struct {
      logic [PW-1:0] prod;
      int            lat;
      int            acc_cyc;
   } exp_t;

   exp_t sb_q[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   bit   b2b   = 0;
   bit   have_prev = 0;
   int   prev_acc  = 0;
   int   prev_lat  = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic chk(input string nm, input longint act, input longint exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Exact product from plain integer arithmetic.
   function automatic logic [PW-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic s);
      longint pa;
      longint pb;
      if (s) begin
         pa = longint'($signed(a));
         pb = longint'($signed(b));
      end else begin
         pa = longint'(a);
         pb = longint'(b);
      end
      return PW'(pa * pb);
   endfunction

   // Edges from accept until out_valid is first sampled high.
   function automatic int ref_lat(input logic [W-1:0] b);
`ifdef SEQ_MUL_EARLY_TERM_EN
      int m;
      m = 0;
      for (int i = 0; i < int'(W); i++) if (b[i]) m = i;
      return m + 2;
`else
      return int'(W) + 1;
`endif
   endfunction

   // Present one operation, wait for acceptance, queue its expected result.
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
      exp_t e;
      bit   ok;
      ok        = 0;
      in_valid  = 1'b1;
      in_mcand  = a;
      in_mplier = b;
      in_signed = s;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1;
            break;
         end
      end
      if (!ok) begin
         total++;
         bad++;
         $display("FAIL accept_timeout: in_ready stayed 0, required 1 within 200 cycles");
      end else begin
         e.prod    = ref_prod(a, b, s);
         e.lat     = ref_lat(b);
         e.acc_cyc = cyc + 1;
         if (b2b && have_prev) chk("accept_spacing", e.acc_cyc - prev_acc, prev_lat + 1);
         prev_acc  = e.acc_cyc;
         prev_lat  = e.lat;
         have_prev = 1;
         sb_q.push_back(e);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      bit ok;
      ok = 0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (sb_q.size() == 0 && !out_valid) begin
            ok = 1;
            break;
         end
      end
      if (!ok) begin
         total++;
         bad++;
         $display("FAIL drain_timeout: %0d results still pending, required 0", sb_q.size());
      end
      @(posedge clk);
      #1;
   endtask

   // Monitor: pop on the first cycle of each result, then check it stays stable while held.
   initial begin
      exp_t cur;
      bit   seen;
      seen = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            seen = 0;
         end else if (out_valid) begin
            if (!seen) begin
               if (sb_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_output: got out_valid=1 product 0x%0h, required no result",
                           out_product);
               end else begin
                  cur  = sb_q.pop_front();
                  seen = 1;
                  chk("latency", longint'(cyc + 1 - cur.acc_cyc), longint'(cur.lat));
               end
            end
            if (seen) begin
               chk("product", longint'(out_product), longint'(cur.prod));
               chk("in_ready_in_done", longint'(in_ready), 0);
               chk("busy_in_done", longint'(busy), 1);
            end
            if (out_ready) seen = 0;
         end
      end
   end

   initial begin
      bit ok;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_signed = 1'b0;
      in_mcand  = '0;
      in_mplier = '0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_in_ready", longint'(in_ready), 1);
      chk("reset_out_valid", longint'(out_valid), 0);
      chk("reset_busy", longint'(busy), 0);
      chk("reset_product", longint'(out_product), 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Directed corners in both modes.
      issue(16'hFFFF, 16'hFFFF, 1'b0);
      issue(16'h0003, 16'hFFFB, 1'b1);
      issue(16'h8000, 16'h8000, 1'b1);
      issue(16'hFFFF, 16'hFFFF, 1'b1);
      issue(16'hABCD, 16'h0001, 1'b0);
      issue(16'hABCD, 16'h0100, 1'b0);
      issue(16'h0005, 16'hFFFF, 1'b1);
      issue(16'h0000, 16'h1234, 1'b0);
      issue(16'h4321, 16'h0000, 1'b1);
      drain();

      // Backpressure: hold the result for 10 cycles, then release.
      out_ready = 1'b0;
      issue(16'h1357, 16'h2468, 1'b0);
      ok = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (out_valid) begin
            ok = 1;
            break;
         end
      end
      if (!ok) begin
         total++;
         bad++;
         $display("FAIL backpressure_timeout: out_valid stayed 0, required 1 within 100 cycles");
      end
      repeat (10) @(negedge clk);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("bp_in_ready_after_release", longint'(in_ready), 1);
      chk("bp_out_valid_after_release", longint'(out_valid), 0);
      chk("bp_busy_after_release", longint'(busy), 0);
      @(posedge clk);
      #1;

      // Reset while the counter is at 7; the aborted operation must never surface.
      issue(16'hFFFF, 16'hFFFF, 1'b0);
      repeat (7) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midop_out_valid", longint'(out_valid), 0);
      chk("midop_in_ready", longint'(in_ready), 1);
      chk("midop_busy", longint'(busy), 0);
      chk("midop_product", longint'(out_product), 0);
      sb_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      issue(16'h1234, 16'h0010, 1'b0);
      drain();

      // Random back-to-back traffic, unsigned then signed, out_ready held high.
      b2b       = 1;
      have_prev = 0;
      for (int m = 0; m < 2; m++) begin
         for (int i = 0; i < 100; i++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            a = W'($urandom);
            case ($urandom_range(0, 3))
               0:       b = W'($urandom_range(0, 255));
               1:       b = W'(1) << $urandom_range(0, W - 1);
               default: b = W'($urandom);
            endcase
            issue(a, b, m[0]);
         end
      end
      b2b = 0;
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_seq_mul_engine

// File: doc/seq_mul_engine.md
Name: seq_mul_engine

Overview:
- Parametrised sequential shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH.
- Successor to the fixed 16x16 accumulator-update datapath. Adds a cycle counter, FSM, valid/ready handshakes, a signed two's-complement mode and optional early termination.
- Sits between the operand issue stage and result writeback in the multiply unit.

Parameters:
- WIDTH, 16, operand width in bits; legal range 2..64.
- CNT_W, $clog2(WIDTH), step counter width; derived, not overridden.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  engine can accept operands.
- in_signed  input  1  1 = two's-complement operands; 0 = unsigned.
- in_mcand  input  WIDTH  multiplicand.
- in_mplier  input  WIDTH  multiplier.
- out_valid  output  1  product valid.
- out_ready  input  1  consumer accepts product.
- out_product  output  2*WIDTH  product.
- busy  output  1  high in CALC or DONE.

Behaviour:
- Reset (async assert, sync deassert by rst_n):
  - FSM goes to IDLE.
  - in_ready=1, out_valid=0, busy=0.
  - out_product=0, counter=0, accumulator=0.
- FSM states: IDLE, CALC, DONE.
  - IDLE: in_ready=1. On in_valid&in_ready, capture mcand, mplier and signed flag; clear the accumulator and counter; go to CALC.
  - CALC: one multiplier bit per cycle, LSB first, counter 0..WIDTH-1. After step WIDTH-1, go to DONE.
  - DONE: out_valid=1 and out_product stable. On out_ready, go to IDLE.
- Input rules:
  - in_ready=0 outside IDLE; in_valid there is ignored.
  - Operand inputs are sampled only on the accept edge.
- Step datapath (right-shift form). The accumulator is {hi[WIDTH:0], lo[WIDTH-1:0]}.
  - pp = mplier bit k ? mcand : 0.
  - Unsigned: sum = {1'b0,hi[WIDTH-1:0]} + {1'b0,pp}.
  - Signed: sum = sext(hi) + sext(pp), except at the final step (k=WIDTH-1), where sum = sext(hi) - sext(pp).
  - New accumulator = {sum, hi-bit-drop into lo}: the sum shifts right by 1, its LSB enters lo[WIDTH-1], and lo shifts right.
  - Signed mode shifts arithmetically (the sign is replicated into hi[WIDTH]).
  - out_product = {hi[WIDTH-1:0], lo}. The result is exact; there is no overflow in either mode.
- Latency: accept at edge T, out_valid high from edge T+WIDTH+1. Throughput is one op per WIDTH+2 cycles with out_ready held high.
- Backpressure: out_valid and out_product are held indefinitely while out_ready=0.
- in_ready rises the cycle after the output handshake; there is no same-cycle accept in DONE.
- Reset mid-operation (CALC or DONE): the operation is abandoned immediately, outputs return to reset values, and no result is emitted.
- Degenerate operands: mcand=0 or mplier=0 produces 0 with normal latency, unless the optional feature below is enabled.

Optional Feature:
- Macro: SEQ_MUL_EARLY_TERM_EN.
- Defined:
  - In CALC, after processing bit k, if all remaining multiplier bits [WIDTH-1:k+1] are 0, the engine shifts the accumulator right by the remaining count (WIDTH-1-k) in that same cycle and goes to DONE.
  - Signed-mode negative multipliers never terminate early, because their sign bit is 1.
  - Minimum latency is 2 cycles (mplier=0 or 1).
  - Result values are identical to the non-early-termination build.
- Undefined: latency is always WIDTH+1. The remaining-bits check is absent.

Decomposition:
- Shared package seq_mul_pkg:
  - typedef enum logic [1:0] seq_mul_state_t {IDLE, CALC, DONE}.
  - localparam SEQ_MUL_DEF_WIDTH = 16.
- Natural sub-module mul_acc_step: combinational, one step. Parameters WIDTH. Inputs acc, pp, signed flag, last-step flag. Output next acc.
- The top level holds the FSM, counter, operand registers and handshakes.

Test Plan (WIDTH=16 unless noted):
- Unsigned: 0xFFFF x 0xFFFF -> 0xFFFE0001. out_valid first at accept+17.
- Signed: 0x0003 x 0xFFFB (3 x -5) -> 0xFFFFFFF1. 0x8000 x 0x8000 -> 0x40000000. 0xFFFF x 0xFFFF -> 0x00000001.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> product stable, in_ready=0 throughout. Release -> in_ready=1 next cycle.
- Reset mid-op: assert rst_n=0 at counter=7 -> all outputs reset asynchronously. The next op, 0x1234 x 0x0010, gives 0x00012340.
- Back-to-back: 100 random ops in each mode with out_ready=1 against a reference model -> exact match, 18-cycle spacing. Repeat at WIDTH=4 and WIDTH=32.
- With SEQ_MUL_EARLY_TERM_EN defined:
  - 0xABCD x 0x0001 -> 0x0000ABCD at accept+2.
  - 0xABCD x 0x0100 -> 0x00ABCD00 at accept+10.
  - Signed 5 x -1 -> 0xFFFFFFFB at accept+17.
